// File: rtl/axis_byte_packer_if.sv
// AXI-Stream bundle shared by the byte packer's input and output sides.
// The slave view exposes only what the packer reads from its upstream.
interface axis_byte_packer_if #(
    parameter int DATA_W = 8,
    parameter int KEEP_W = 1
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_byte_packer.sv
// Packs a byte-wide AXI-Stream into little-endian words of RATIO bytes.
// A packet tail shorter than RATIO bytes is flushed on tlast as a partial
// word with a contiguous keep mask. The output side is fully registered and
// the input stays ready whenever the output register is empty or draining,
// so one byte per cycle is sustained while the sink is ready.
module axis_byte_packer #(
    parameter int IN_W  = 8,
    parameter int RATIO = 4
) (
    input  logic                aclk,
    input  logic                aresetn,
    axis_byte_packer_if.slave   s_axis,
    axis_byte_packer_if.master  m_axis
);
    localparam int IDX_W = $clog2(RATIO);
    localparam int OUT_W = IN_W * RATIO;

    logic [OUT_W-1:0] asm_q, asm_d;
    logic [RATIO-1:0] keep_q, keep_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0] out_keep_q, out_keep_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;

    logic             s_ready;
    logic             s_fire;
    logic             m_fire;
    logic             complete;
    logic [OUT_W-1:0] asm_word;
    logic [RATIO-1:0] keep_word;

    assign s_ready          = ~out_valid_q | m_axis.tready;
    assign s_axis.tready    = s_ready;
    assign m_axis.tdata     = out_data_q;
    assign m_axis.tkeep     = out_keep_q;
    assign m_axis.tvalid    = out_valid_q;
    assign m_axis.tlast     = out_last_q;

    // Handshakes and the assembly word as it would look with the incoming byte merged in
    always_comb begin
        s_fire   = s_axis.tvalid & s_ready;
        m_fire   = out_valid_q & m_axis.tready;
        asm_word = asm_q;
        asm_word[idx_q*IN_W +: IN_W] = s_axis.tdata;
        keep_word = keep_q | (RATIO'(1) << idx_q);
        complete  = s_fire & ((idx_q == IDX_W'(RATIO - 1)) | s_axis.tlast);
    end

    // Next-state: accumulate bytes, hand a finished word to the output register, drain on m_fire
    always_comb begin
        asm_d       = asm_q;
        keep_d      = keep_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (m_fire) begin
            out_valid_d = 1'b0;
        end

        if (s_fire) begin
            if (complete) begin
                out_data_d  = asm_word;
                out_keep_d  = keep_word;
                out_last_d  = s_axis.tlast;
                out_valid_d = 1'b1;
                asm_d       = '0;
                keep_d      = '0;
                idx_d       = '0;
            end else begin
                asm_d  = asm_word;
                keep_d = keep_word;
                idx_d  = idx_q + IDX_W'(1);
            end
        end
    end

    // State registers; reset discards any partial word and empties the output
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            asm_q       <= '0;
            keep_q      <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            asm_q       <= asm_d;
            keep_q      <= keep_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end
endmodule

// File: tb/tb_axis_byte_packer.sv
// Directed self-checking bench for axis_byte_packer (IN_W=8, RATIO=4).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_axis_byte_packer;
    logic aclk;
    logic aresetn;

    int checks = 0;
    int errors = 0;

    axis_byte_packer_if #(.DATA_W(8),  .KEEP_W(1)) s_if ();
    axis_byte_packer_if #(.DATA_W(32), .KEEP_W(4)) m_if ();

    axis_byte_packer #(
        .IN_W  (8),
        .RATIO (4)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axis  (s_if),
        .m_axis  (m_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Drive the upstream side for the next edge
    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic last);
        s_if.tvalid = valid;
        s_if.tdata  = data;
        s_if.tlast  = last;
    endtask

    // Single comparison with failure accounting
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the whole output word register
    task automatic checkWord(input string tag, input logic [31:0] data, input logic [3:0] keep, input logic last);
        checkOutput({tag, ".valid"}, 64'(m_if.tvalid), 64'(1'b1));
        checkOutput({tag, ".data"},  64'(m_if.tdata),  64'(data));
        checkOutput({tag, ".keep"},  64'(m_if.tkeep),  64'(keep));
        checkOutput({tag, ".last"},  64'(m_if.tlast),  64'(last));
    endtask

    initial begin
        aresetn     = 1'b0;
        s_if.tkeep  = 1'b1;
        m_if.tready = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Reset state
        #3;
        checkOutput("rst.valid",  64'(m_if.tvalid), 64'(0));
        checkOutput("rst.data",   64'(m_if.tdata),  64'(0));
        checkOutput("rst.keep",   64'(m_if.tkeep),  64'(0));
        checkOutput("rst.last",   64'(m_if.tlast),  64'(0));
        checkOutput("rst.sready", 64'(s_if.tready), 64'(1));
        tick();
        tick();
        aresetn = 1'b1;
        $display("[TB] reset released");

        // Reset mid-word discards the partial word
        applyStimulus(1'b1, 8'hAA, 1'b0); tick();
        applyStimulus(1'b1, 8'hBB, 1'b0); tick();
        applyStimulus(1'b0, 8'h00, 1'b0);
        aresetn = 1'b0;
        #1;
        checkOutput("midrst.valid",  64'(m_if.tvalid), 64'(0));
        checkOutput("midrst.data",   64'(m_if.tdata),  64'(0));
        checkOutput("midrst.keep",   64'(m_if.tkeep),  64'(0));
        checkOutput("midrst.sready", 64'(s_if.tready), 64'(1));
        #2;
        aresetn = 1'b1;
        applyStimulus(1'b1, 8'h01, 1'b0); tick();
        applyStimulus(1'b1, 8'h02, 1'b0); tick();
        applyStimulus(1'b1, 8'h03, 1'b0); tick();
        checkOutput("fresh.novalid", 64'(m_if.tvalid), 64'(0));
        applyStimulus(1'b1, 8'h04, 1'b0); tick();
        checkWord("fresh", 32'h04030201, 4'hF, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0); tick();
        checkOutput("fresh.drain", 64'(m_if.tvalid), 64'(0));

        // Full word with a gap in input valid mid-word
        applyStimulus(1'b1, 8'h11, 1'b0); tick();
        applyStimulus(1'b1, 8'h22, 1'b0); tick();
        applyStimulus(1'b0, 8'hEE, 1'b1); tick();
        applyStimulus(1'b1, 8'h33, 1'b0); tick();
        checkOutput("full.novalid", 64'(m_if.tvalid), 64'(0));
        applyStimulus(1'b1, 8'h44, 1'b1); tick();
        checkWord("full", 32'h44332211, 4'hF, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0); tick();
        checkOutput("full.drain", 64'(m_if.tvalid), 64'(0));

        // Partial word flushed on tlast
        applyStimulus(1'b1, 8'hA1, 1'b0); tick();
        applyStimulus(1'b1, 8'hB2, 1'b0); tick();
        applyStimulus(1'b1, 8'hC3, 1'b1); tick();
        checkWord("partial", 32'h00C3B2A1, 4'h7, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0); tick();
        checkOutput("partial.drain", 64'(m_if.tvalid), 64'(0));

        // Single-byte packet lands in lane 0 after the partial word
        applyStimulus(1'b1, 8'h5A, 1'b1); tick();
        checkWord("single", 32'h0000005A, 4'h1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0); tick();
        checkOutput("single.drain", 64'(m_if.tvalid), 64'(0));

        // Backpressure holds the word and blocks input
        m_if.tready = 1'b0;
        applyStimulus(1'b1, 8'h10, 1'b0); tick();
        applyStimulus(1'b1, 8'h20, 1'b0); tick();
        applyStimulus(1'b1, 8'h30, 1'b0); tick();
        applyStimulus(1'b1, 8'h40, 1'b1); tick();
        checkWord("bp", 32'h40302010, 4'hF, 1'b1);
        applyStimulus(1'b1, 8'h50, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp.sready", 64'(s_if.tready), 64'(0));
            tick();
            checkWord("bp.hold", 32'h40302010, 4'hF, 1'b1);
        end
        m_if.tready = 1'b1;
        #1;
        checkOutput("bp.release.sready", 64'(s_if.tready), 64'(1));
        tick();
        checkOutput("bp.once", 64'(m_if.tvalid), 64'(0));
        applyStimulus(1'b1, 8'h60, 1'b0); tick();
        applyStimulus(1'b1, 8'h70, 1'b0); tick();
        applyStimulus(1'b1, 8'h80, 1'b1); tick();
        checkWord("bp.nolost", 32'h80706050, 4'hF, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0); tick();

        // Streaming 12 bytes, one word every 4 cycles
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(1'b1, 8'(i), i == 12);
            tick();
            if (i % 4 == 0) begin
                checkWord("stream", {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)}, 4'hF, i == 12);
            end else begin
                checkOutput("stream.idle", 64'(m_if.tvalid), 64'(0));
            end
        end
        applyStimulus(1'b0, 8'h00, 1'b0); tick();
        checkOutput("stream.drain", 64'(m_if.tvalid), 64'(0));

        // Back-to-back single-byte packets reload the output without a bubble
        applyStimulus(1'b1, 8'hC1, 1'b1); tick();
        checkWord("b2b1", 32'h000000C1, 4'h1, 1'b1);
        applyStimulus(1'b1, 8'hC2, 1'b1); tick();
        checkWord("b2b2", 32'h000000C2, 4'h1, 1'b1);
        applyStimulus(1'b1, 8'hC3, 1'b1); tick();
        checkWord("b2b3", 32'h000000C3, 4'h1, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0); tick();
        checkOutput("b2b.drain", 64'(m_if.tvalid), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
